sdio_host_cmd_phy: RTL and testbench
====================================

Name: sdio_host_cmd_phy

Overview:
- Host-side SDIO CMD-line PHY; the opposite end of the device command PHY.
- Serialises a 48-bit command frame (start, dir=1, index, argument, CRC7, end) onto CMD.
- Releases the line, waits for the device response and deserialises it. Checks the response CRC7 and reports a response, a timeout or no-response completion to the host link layer.
- Sits between the host command controller and the CMD pad tristate, in the sdio_host_model bench path and the FPGA host core.

Parameters:
RSPS_TIMEOUT, 64, max clocks between the end of command turnaround and the response start bit (Ncr) before timeout
CMD_GAP, 8, clocks the line is driven high after a transaction before o_cmd_idle asserts (Ncc)

Ports:
clk  in  1  SDIO clock; all logic on posedge
rst  in  1  asynchronous active-high reset
i_cmd_stb  in  1  start command; accepted only while o_cmd_idle=1
i_cmd  in  6  command index
i_cmd_arg  in  32  command argument
i_rsps_en  in  1  1 = expect 48-bit response; 0 = no response (e.g. CMD0)
o_cmd_idle  out  1  PHY ready for i_cmd_stb
o_cmd_done_stb  out  1  one-cycle pulse at end of every transaction
o_rsps_stb  out  1  one-cycle pulse; response captured
o_rsps  out  40  response bits 47..8 (start, dir, index, arg)
o_rsps_crc_good  out  1  valid with o_rsps_stb; received CRC7 matches computed CRC7
o_rsps_end_err  out  1  valid with o_rsps_stb; sampled end bit was 0
o_rsps_timeout  out  1  valid with o_cmd_done_stb; no start bit within RSPS_TIMEOUT
o_sdio_cmd_dir  out  1  1 = host drives CMD
o_sdio_cmd_out  out  1  CMD output value
i_sdio_cmd_in  in  1  CMD input value

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - state=IDLE; o_cmd_idle=1; o_sdio_cmd_dir=0; o_sdio_cmd_out=1.
  - All strobes and flags 0; o_rsps=0.
- State machine and transitions:
  - IDLE: dir=0, out=1. On i_cmd_stb, latch {2'b01, i_cmd, i_cmd_arg} into a 40-bit shift register and capture i_rsps_en; o_cmd_idle falls the next cycle. -> CMD_TX.
  - CMD_TX: dir=1. Drive shift MSB each cycle for 40 cycles; the first driven bit (0) appears the cycle after the accepted strobe. CRC7 is fed the driven bit. -> CMD_CRC.
  - CMD_CRC: drive CRC7[6:0], MSB first, 7 cycles. -> CMD_END.
  - CMD_END: drive 1 for one cycle. -> TURNAROUND.
  - TURNAROUND: dir=0 for 2 cycles (Nz), CRC reset. Then -> WAIT_RSPS if i_rsps_en, else -> GAP.
  - WAIT_RSPS: count cycles.
    - First sampled i_sdio_cmd_in=0 counts as the start bit, shifted in -> RSPS_RX.
    - Counter reaching RSPS_TIMEOUT sets timeout -> GAP.
  - RSPS_RX: sample 39 more bits; all 40 feed CRC7 and o_rsps shift. -> RSPS_CRC.
  - RSPS_CRC: sample 7 bits into received CRC register. -> RSPS_END.
  - RSPS_END: sample end bit. Next cycle pulse o_rsps_stb with o_rsps, o_rsps_crc_good and o_rsps_end_err. -> GAP.
  - GAP: dir=1, out=1 for CMD_GAP cycles. On the last cycle pulse o_cmd_done_stb with o_rsps_timeout. -> IDLE.
- Response flag persistence: o_rsps, o_rsps_crc_good and o_rsps_end_err hold until the next accepted command.
- Total frame length: command 48 cycles + turnaround 2 + response 48.
- Bit and cycle counters: 8 bits wide, no wrap within a legal frame. The timeout counter saturates at RSPS_TIMEOUT.
- Boundary conditions:
  - i_cmd_stb while not idle is ignored.
  - i_cmd_stb in the same cycle o_cmd_idle rises is accepted.
  - A 0 seen in TURNAROUND is ignored; it is bus contention and is not a start bit.
  - A timeout exactly at count RSPS_TIMEOUT means a start bit on that same cycle loses.
- CRC7 polynomial x^7+x^3+1, initial value 0.

Optional Feature:
SDIO_HOST_RSPS_CRC_CHECK_EN
- Defined: response CRC7 is computed and compared; o_rsps_crc_good reflects the match.
- Undefined: receive-side CRC logic is removed; o_rsps_crc_good is tied 1. Transmit CRC generation always remains.

Decomposition:
- sdio_defines.v holds host PHY state encodings, SDIO_CMD_FRAME_LEN (48), SDIO_RSPS_SHORT_LEN (48), SDIO_NZ_CYCLES (2) and CRC width.
- Reuse existing crc7 (clk/rst/bit/en/crc), one instance time-shared between TX and RX.
- No further sub-module.

Test Plan:
- CMD0: i_cmd=0, arg=0, i_rsps_en=0 -> CMD line carries 0x400000000095 MSB first, dir=0 for 2 cycles, 8 high cycles, then o_cmd_done_stb with o_rsps_timeout=0 and no o_rsps_stb.
- CMD8: arg=0x000001AA, i_rsps_en=1 -> TX frame 0x48000001AA87. Device model replies 0x08000001AA plus model-computed CRC after 5 cycles -> o_rsps=0x08000001AA, crc_good=1, end_err=0.
- Same CMD8 with one flipped CRC bit in the reply -> crc_good=0; with end bit 0 -> end_err=1.
- Silent device, i_rsps_en=1 -> o_cmd_done_stb with o_rsps_timeout=1 exactly RSPS_TIMEOUT+CMD_GAP cycles after turnaround.
- Back-to-back i_cmd_stb held high -> second command starts the cycle after o_cmd_idle rises; strobes during the frame are ignored.
- rst asserted mid-CMD_TX (bit 20) -> dir=0 and out=1 immediately; o_cmd_idle=1; no done strobe; next command transmits cleanly.

Source files
------------

// File: rtl/sdio_host_cmd_phy_pkg.sv
// Shared state encoding, frame constants and CRC7 step for the host CMD-line PHY.
package sdio_host_cmd_phy_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD_TX,
        ST_CMD_CRC,
        ST_CMD_END,
        ST_TURNAROUND,
        ST_WAIT_RSPS,
        ST_RSPS_RX,
        ST_RSPS_CRC,
        ST_RSPS_END,
        ST_GAP
    } phy_state_t;

    localparam int SDIO_CMD_FRAME_LEN  = 48;
    localparam int SDIO_RSPS_SHORT_LEN = 48;
    localparam int SDIO_NZ_CYCLES      = 2;
    localparam int CRC_W               = 7;
    localparam int BODY_W              = SDIO_CMD_FRAME_LEN - CRC_W - 1;

    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    // One serial step of x^7 + x^3 + 1, data MSB first.
    function automatic logic [CRC_W-1:0] crc7_next(input logic [CRC_W-1:0] crc, input logic din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sdio_host_cmd_phy_crc7.sv
// Serial CRC7 accumulator; i_clr restarts from zero and may absorb a first bit in the same cycle.
import sdio_host_cmd_phy_pkg::*;

module sdio_host_cmd_phy_crc7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= '0;
        end else if (i_clr) begin
            r_crc <= i_en ? crc7_next(7'd0, i_bit) : 7'd0;
        end else if (i_en) begin
            r_crc <= crc7_next(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sdio_host_cmd_phy.sv
// Host SDIO CMD-line PHY: sends a 48-bit command, optionally receives a 48-bit response.
// Optional receive CRC check: define SDIO_HOST_RSPS_CRC_CHECK_EN (otherwise o_rsps_crc_good is tied 1).
import sdio_host_cmd_phy_pkg::*;

module sdio_host_cmd_phy #(
    parameter int RSPS_TIMEOUT = 64,
    parameter int CMD_GAP      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_stb,
    input  logic [5:0]  i_cmd,
    input  logic [31:0] i_cmd_arg,
    input  logic        i_rsps_en,
    output logic        o_cmd_idle,
    output logic        o_cmd_done_stb,
    output logic        o_rsps_stb,
    output logic [39:0] o_rsps,
    output logic        o_rsps_crc_good,
    output logic        o_rsps_end_err,
    output logic        o_rsps_timeout,
    output logic        o_sdio_cmd_dir,
    output logic        o_sdio_cmd_out,
    input  logic        i_sdio_cmd_in
);

    localparam logic [7:0] LAST_BODY = 8'(BODY_W - 1);
    localparam logic [7:0] LAST_CRC  = 8'(CRC_W - 1);
    localparam logic [7:0] LAST_NZ   = 8'(SDIO_NZ_CYCLES - 1);
    localparam logic [7:0] TO_LAST   = 8'(RSPS_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST  = 8'(CMD_GAP - 1);

    phy_state_t  r_state;
    logic [39:0] r_shift;
    logic [7:0]  r_cnt;
    logic        r_rsps_en;
    logic        r_cmd_idle;
    logic        r_done_stb;
    logic        r_rsps_stb;
    logic [39:0] r_rsps;
    logic        r_end_err;
    logic        r_timeout;
    logic        r_dir;
    logic        r_out;
`ifdef SDIO_HOST_RSPS_CRC_CHECK_EN
    logic [6:0]  r_crc_rx;
    logic        r_crc_good;
`endif

    logic [39:0] w_frame;
    logic [6:0]  w_crc;
    logic        w_crc_clr;
    logic        w_crc_en;
    logic        w_crc_bit;

    assign w_frame = {2'b01, i_cmd, i_cmd_arg};

    // The single CRC engine serves TX, then is cleared in turnaround and reused for RX.
    always_comb begin
        w_crc_clr = (r_state == ST_IDLE) || (r_state == ST_TURNAROUND);
        w_crc_en  = 1'b0;
        w_crc_bit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_crc_en  = i_cmd_stb;
                w_crc_bit = w_frame[39];
            end
            ST_CMD_TX: begin
                w_crc_en  = (r_cnt != LAST_BODY);
                w_crc_bit = r_shift[39];
            end
`ifdef SDIO_HOST_RSPS_CRC_CHECK_EN
            ST_WAIT_RSPS: begin
                w_crc_en  = (r_cnt != TO_LAST) && !i_sdio_cmd_in;
                w_crc_bit = i_sdio_cmd_in;
            end
            ST_RSPS_RX: begin
                w_crc_en  = 1'b1;
                w_crc_bit = i_sdio_cmd_in;
            end
`endif
            default: ;
        endcase
    end

    sdio_host_cmd_phy_crc7 u_crc7 (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_crc_clr),
        .i_en  (w_crc_en),
        .i_bit (w_crc_bit),
        .o_crc (w_crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_rsps_en  <= 1'b0;
            r_cmd_idle <= 1'b1;
            r_done_stb <= 1'b0;
            r_rsps_stb <= 1'b0;
            r_rsps     <= '0;
            r_end_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_dir      <= 1'b0;
            r_out      <= 1'b1;
`ifdef SDIO_HOST_RSPS_CRC_CHECK_EN
            r_crc_rx   <= '0;
            r_crc_good <= 1'b0;
`endif
        end else begin
            r_done_stb <= 1'b0;
            r_rsps_stb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_stb) begin
                        r_shift    <= {w_frame[38:0], 1'b0};
                        r_out      <= w_frame[39];
                        r_dir      <= 1'b1;
                        r_cmd_idle <= 1'b0;
                        r_rsps_en  <= i_rsps_en;
                        r_cnt      <= '0;
                        r_rsps     <= '0;
                        r_end_err  <= 1'b0;
                        r_timeout  <= 1'b0;
`ifdef SDIO_HOST_RSPS_CRC_CHECK_EN
                        r_crc_good <= 1'b0;
`endif
                        r_state    <= ST_CMD_TX;
                    end
                end
                ST_CMD_TX: begin
                    if (r_cnt == LAST_BODY) begin
                        r_out   <= w_crc[6];
                        r_cnt   <= '0;
                        r_state <= ST_CMD_CRC;
                    end else begin
                        r_out   <= r_shift[39];
                        r_shift <= {r_shift[38:0], 1'b0};
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                ST_CMD_CRC: begin
                    if (r_cnt == LAST_CRC) begin
                        r_out   <= 1'b1;
                        r_state <= ST_CMD_END;
                    end else begin
                        r_out <= w_crc[3'd5 - r_cnt[2:0]];
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_CMD_END: begin
                    r_dir   <= 1'b0;
                    r_out   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_TURNAROUND;
                end
                ST_TURNAROUND: begin
                    if (r_cnt == LAST_NZ) begin
                        r_cnt <= '0;
                        if (r_rsps_en) begin
                            r_state <= ST_WAIT_RSPS;
                        end else begin
                            r_dir   <= 1'b1;
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_WAIT_RSPS: begin
                    // Timeout is checked first so a start bit on the final count loses.
                    if (r_cnt == TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_dir     <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_GAP;
                    end else if (!i_sdio_cmd_in) begin
                        r_shift <= {r_shift[38:0], 1'b0};
                        r_cnt   <= 8'd1;
                        r_state <= ST_RSPS_RX;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RSPS_RX: begin
                    r_shift <= {r_shift[38:0], i_sdio_cmd_in};
                    if (r_cnt == LAST_BODY) begin
                        r_cnt   <= '0;
                        r_state <= ST_RSPS_CRC;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RSPS_CRC: begin
`ifdef SDIO_HOST_RSPS_CRC_CHECK_EN
                    r_crc_rx <= {r_crc_rx[5:0], i_sdio_cmd_in};
`endif
                    if (r_cnt == LAST_CRC) begin
                        r_state <= ST_RSPS_END;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RSPS_END: begin
                    r_rsps_stb <= 1'b1;
                    r_rsps     <= r_shift;
                    r_end_err  <= !i_sdio_cmd_in;
`ifdef SDIO_HOST_RSPS_CRC_CHECK_EN
                    r_crc_good <= (r_crc_rx == w_crc);
`endif
                    r_dir      <= 1'b1;
                    r_out      <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_dir      <= 1'b0;
                        r_cmd_idle <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        if (r_cnt == GAP_LAST - 8'd1) r_done_stb <= 1'b1;
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_idle     = r_cmd_idle;
    assign o_cmd_done_stb = r_done_stb;
    assign o_rsps_stb     = r_rsps_stb;
    assign o_rsps         = r_rsps;
    assign o_rsps_end_err = r_end_err;
    assign o_rsps_timeout = r_timeout;
    assign o_sdio_cmd_dir = r_dir;
    assign o_sdio_cmd_out = r_out;
`ifdef SDIO_HOST_RSPS_CRC_CHECK_EN
    assign o_rsps_crc_good = r_crc_good;
`else
    assign o_rsps_crc_good = 1'b1;
`endif

endmodule

// File: tb/tb_sdio_host_cmd_phy.sv
// Bench for sdio_host_cmd_phy: directed commands, a device reply model and a queue-based monitor.
`timescale 1ns/1ps

module tb_sdio_host_cmd_phy;

    localparam int RSPS_TIMEOUT = 64;
    localparam int CMD_GAP      = 8;

`ifdef SDIO_HOST_RSPS_CRC_CHECK_EN
    localparam logic BAD_CRC_GOOD = 1'b0;
    localparam logic RST_CRC_GOOD = 1'b0;
`else
    localparam logic BAD_CRC_GOOD = 1'b1;
    localparam logic RST_CRC_GOOD = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmd_stb;
    logic [5:0]  i_cmd;
    logic [31:0] i_cmd_arg;
    logic        i_rsps_en;
    logic        o_cmd_idle;
    logic        o_cmd_done_stb;
    logic        o_rsps_stb;
    logic [39:0] o_rsps;
    logic        o_rsps_crc_good;
    logic        o_rsps_end_err;
    logic        o_rsps_timeout;
    logic        o_sdio_cmd_dir;
    logic        o_sdio_cmd_out;
    logic        i_sdio_cmd_in;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int unsigned cyc = 0;

    // exp entries: tx = frame; rsps = {rsps, crc_good, end_err, cycle}; done = {timeout, cycle}
    logic [47:0] exp_tx_q[$];
    logic [57:0] exp_rsps_q[$];
    logic [16:0] exp_done_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdio_host_cmd_phy #(.RSPS_TIMEOUT(RSPS_TIMEOUT), .CMD_GAP(CMD_GAP)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_cmd_stb       (i_cmd_stb),
        .i_cmd           (i_cmd),
        .i_cmd_arg       (i_cmd_arg),
        .i_rsps_en       (i_rsps_en),
        .o_cmd_idle      (o_cmd_idle),
        .o_cmd_done_stb  (o_cmd_done_stb),
        .o_rsps_stb      (o_rsps_stb),
        .o_rsps          (o_rsps),
        .o_rsps_crc_good (o_rsps_crc_good),
        .o_rsps_end_err  (o_rsps_end_err),
        .o_rsps_timeout  (o_rsps_timeout),
        .o_sdio_cmd_dir  (o_sdio_cmd_dir),
        .o_sdio_cmd_out  (o_sdio_cmd_out),
        .i_sdio_cmd_in   (i_sdio_cmd_in)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [6:0] model_crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (!o_cmd_idle && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!o_cmd_idle) check("idle_wait_budget", 64'(o_cmd_idle), 64'd1);
    endtask

    // Frame cycle k = k-th cycle after the strobe is accepted; cycles 0..47 command, 48..49 turnaround.
    task automatic do_txn(input logic [5:0] idx, input logic [31:0] arg, input logic en,
                          input logic [47:0] exp_tx, input bit reply, input int d,
                          input logic [39:0] body, input bit flip, input logic end_bit,
                          input bit contend, input int rsps_off, input logic exp_good,
                          input logic exp_end_err, input logic exp_to, input int done_off);
        logic [6:0]  c;
        logic [47:0] rf;
        wait_idle();
        exp_tx_q.push_back(exp_tx);
        if (rsps_off >= 0) exp_rsps_q.push_back({body, exp_good, exp_end_err, 16'(rsps_off)});
        exp_done_q.push_back({exp_to, 16'(done_off)});
        i_cmd     = idx;
        i_cmd_arg = arg;
        i_rsps_en = en;
        i_cmd_stb = 1'b1;
        @(negedge clk);
        i_cmd_stb = 1'b0;
        repeat (48) @(negedge clk);
        if (contend) i_sdio_cmd_in = 1'b0;
        repeat (2) @(negedge clk);
        i_sdio_cmd_in = 1'b1;
        if (reply) begin
            c = model_crc7(body);
            if (flip) c[2] = ~c[2];
            rf = {body, c, end_bit};
            repeat (d) @(negedge clk);
            for (int i = 47; i >= 0; i--) begin
                i_sdio_cmd_in = rf[i];
                @(negedge clk);
            end
            i_sdio_cmd_in = 1'b1;
        end
        wait_idle();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [47:0] tx_bits;
        int          tx_cnt;
        bit          tx_active;
        logic        prev_dir;
        int unsigned f_start;
        bit          dir_ok;
        bit          nz_ok;
        logic [47:0] e_tx;
        logic [57:0] e_rs;
        logic [16:0] e_dn;
        tx_bits = '0; tx_cnt = 0; tx_active = 0; prev_dir = 1'b0;
        f_start = 0; dir_ok = 1; nz_ok = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_active = 0;
                prev_dir  = 1'b0;
            end else begin
                if (tx_active) begin
                    if (tx_cnt < 48) begin
                        tx_bits = {tx_bits[46:0], o_sdio_cmd_out};
                        if (!o_sdio_cmd_dir) dir_ok = 0;
                    end else if (o_sdio_cmd_dir) begin
                        nz_ok = 0;
                    end
                    tx_cnt++;
                    if (tx_cnt == 50) begin
                        tx_active = 0;
                        check("tx_expected", 64'(exp_tx_q.size() != 0), 64'd1);
                        if (exp_tx_q.size() != 0) begin
                            e_tx = exp_tx_q.pop_front();
                            check("tx_frame", 64'(tx_bits), 64'(e_tx));
                        end
                        check("tx_dir_high", 64'(dir_ok), 64'd1);
                        check("turnaround_dir_low", 64'(nz_ok), 64'd1);
                    end
                end else if (o_sdio_cmd_dir && !prev_dir && !o_sdio_cmd_out) begin
                    tx_active = 1;
                    tx_cnt    = 1;
                    tx_bits   = '0;
                    f_start   = cyc;
                    dir_ok    = 1;
                    nz_ok     = 1;
                end
                prev_dir = o_sdio_cmd_dir;

                if (o_rsps_stb) begin
                    check("rsps_expected", 64'(exp_rsps_q.size() != 0), 64'd1);
                    if (exp_rsps_q.size() != 0) begin
                        e_rs = exp_rsps_q.pop_front();
                        check("rsps_data", 64'(o_rsps), 64'(e_rs[57:18]));
                        check("rsps_crc_good", 64'(o_rsps_crc_good), 64'(e_rs[17]));
                        check("rsps_end_err", 64'(o_rsps_end_err), 64'(e_rs[16]));
                        check("rsps_cycle", 64'(cyc - f_start), 64'(e_rs[15:0]));
                    end
                end
                if (o_cmd_done_stb) begin
                    check("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
                    if (exp_done_q.size() != 0) begin
                        e_dn = exp_done_q.pop_front();
                        check("done_timeout", 64'(o_rsps_timeout), 64'(e_dn[16]));
                        check("done_cycle", 64'(cyc - f_start), 64'(e_dn[15:0]));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;
        i_cmd_stb = 1'b0; i_cmd = '0; i_cmd_arg = '0; i_rsps_en = 1'b0; i_sdio_cmd_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_idle", 64'(o_cmd_idle), 64'd1);
        check("rst_dir", 64'(o_sdio_cmd_dir), 64'd0);
        check("rst_out", 64'(o_sdio_cmd_out), 64'd1);
        check("rst_done_stb", 64'(o_cmd_done_stb), 64'd0);
        check("rst_rsps_stb", 64'(o_rsps_stb), 64'd0);
        check("rst_rsps", 64'(o_rsps), 64'd0);
        check("rst_crc_good", 64'(o_rsps_crc_good), 64'(RST_CRC_GOOD));
        check("rst_end_err", 64'(o_rsps_end_err), 64'd0);
        check("rst_timeout", 64'(o_rsps_timeout), 64'd0);

        // CMD0, no response
        do_txn(6'd0, 32'h0, 1'b0, 48'h400000000095, 0, 0, 40'h0, 0, 1'b1, 0,
               -1, 1'b0, 1'b0, 1'b0, 57);
        // CMD8 with good reply after 5 cycles; a 0 during turnaround must be ignored
        do_txn(6'd8, 32'h000001AA, 1'b1, 48'h48000001AA87, 1, 5, 40'h08000001AA, 0, 1'b1, 1,
               103, 1'b1, 1'b0, 1'b0, 110);
        // CMD8 reply with one CRC bit flipped
        do_txn(6'd8, 32'h000001AA, 1'b1, 48'h48000001AA87, 1, 5, 40'h08000001AA, 1, 1'b1, 0,
               103, BAD_CRC_GOOD, 1'b0, 1'b0, 110);
        // CMD8 reply with end bit 0
        do_txn(6'd8, 32'h000001AA, 1'b1, 48'h48000001AA87, 1, 5, 40'h08000001AA, 0, 1'b0, 0,
               103, 1'b1, 1'b1, 1'b0, 110);
        check("rsps_hold_after_done", 64'(o_rsps), 64'h08000001AA);
        // silent device -> timeout
        do_txn(6'd8, 32'h000001AA, 1'b1, 48'h48000001AA87, 0, 0, 40'h0, 0, 1'b1, 0,
               -1, 1'b0, 1'b0, 1'b1, 121);
        // start bit on the last count before timeout is taken
        do_txn(6'd55, 32'h0, 1'b1, 48'h770000000065, 1, 62, 40'h3700000120, 0, 1'b1, 0,
               160, 1'b1, 1'b0, 1'b0, 167);
        // start bit on the timeout count loses
        do_txn(6'd8, 32'h000001AA, 1'b1, 48'h48000001AA87, 1, 63, 40'h08000001AA, 0, 1'b1, 0,
               -1, 1'b0, 1'b0, 1'b1, 121);

        // back-to-back: strobe held high across the whole first frame
        wait_idle();
        exp_tx_q.push_back(48'h770000000065);
        exp_done_q.push_back({1'b0, 16'd57});
        exp_tx_q.push_back(48'h510000000055);
        exp_done_q.push_back({1'b0, 16'd57});
        i_cmd = 6'd55; i_cmd_arg = 32'h0; i_rsps_en = 1'b0; i_cmd_stb = 1'b1;
        @(negedge clk);
        i_cmd = 6'd17;
        n = 0;
        while (!o_cmd_idle && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b2b_idle_cycle", 64'(n), 64'd58);
        @(negedge clk);
        i_cmd_stb = 1'b0;
        check("b2b_second_start", 64'({o_sdio_cmd_dir, o_sdio_cmd_out}), 64'b10);
        wait_idle();

        // reset in the middle of command transmission
        i_cmd = 6'd8; i_cmd_arg = 32'h000001AA; i_rsps_en = 1'b1; i_cmd_stb = 1'b1;
        @(negedge clk);
        i_cmd_stb = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_dir", 64'(o_sdio_cmd_dir), 64'd0);
        check("midrst_out", 64'(o_sdio_cmd_out), 64'd1);
        check("midrst_idle", 64'(o_cmd_idle), 64'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (80) @(negedge clk);
        do_txn(6'd0, 32'h0, 1'b0, 48'h400000000095, 0, 0, 40'h0, 0, 1'b1, 0,
               -1, 1'b0, 1'b0, 1'b0, 57);

        repeat (5) @(negedge clk);
        check("tx_q_drained", 64'(exp_tx_q.size()), 64'd0);
        check("rsps_q_drained", 64'(exp_rsps_q.size()), 64'd0);
        check("done_q_drained", 64'(exp_done_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
